// File: rtl/l2_ar_credit_arbiter_if.sv
// AR request / R snoop bundle for l2_ar_credit_arbiter.
//   s_ar*     : NUM_SI packed tile-side read-address channels (requester i at slice i)
//   m_ar*     : single L2-side read-address channel
//   m_r*      : L2-side R handshake, observed only (never driven by the arbiter)
// Modports:
//   slave  : the arbiter's view (accepts s_ar*, drives m_ar*, snoops m_r*)
//   master : the surrounding fabric's view (drives requests, L2 ready and R beats)
interface l2_ar_credit_arbiter_if #(
  parameter int unsigned NUM_SI = 4,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 8
);
  logic [NUM_SI*ID_W-1:0]   s_arid;
  logic [NUM_SI*ADDR_W-1:0] s_araddr;
  logic [NUM_SI*LEN_W-1:0]  s_arlen;
  logic [NUM_SI-1:0]        s_arvalid;
  logic [NUM_SI-1:0]        s_arready;

  logic [ID_W-1:0]          m_arid;
  logic [ADDR_W-1:0]        m_araddr;
  logic [LEN_W-1:0]         m_arlen;
  logic                     m_arvalid;
  logic                     m_arready;

  logic [ID_W-1:0]          m_rid;
  logic                     m_rlast;
  logic                     m_rvalid;
  logic                     m_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arvalid,
    output s_arready,
    output m_arid, m_araddr, m_arlen, m_arvalid,
    input  m_arready,
    input  m_rid, m_rlast, m_rvalid, m_rready
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arvalid,
    input  s_arready,
    input  m_arid, m_araddr, m_arlen, m_arvalid,
    output m_arready,
    output m_rid, m_rlast, m_rvalid, m_rready
  );
endinterface

// File: rtl/l2_ar_credit_arbiter.sv
// Credit-limited round-robin arbiter for AXI read-address requests in front of an L2 master port.
// Each requester may hold at most MAX_OUT_SI outstanding bursts, and all requesters together at
// most MAX_OUT_ALL. A credit is taken when a request is accepted on the requester side and given
// back when the last R beat of the burst is accepted on the master side; the requester is
// identified by the ARID/RID field at [SRC_LSB +: $clog2(NUM_SI)].
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   bus       : l2_ar_credit_arbiter_if.slave (s_ar* in, m_ar* out registered, m_r* snooped)
//   out_total : registered global outstanding-burst count
//   err       : sticky flag, set by a credit return that has no matching outstanding burst
module l2_ar_credit_arbiter #(
  parameter int unsigned NUM_SI      = 4,
  parameter int unsigned ID_W        = 16,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned SRC_LSB     = 12,
  parameter int unsigned MAX_OUT_SI  = 4,
  parameter int unsigned MAX_OUT_ALL = 16,
  localparam int unsigned TOT_W      = $clog2(MAX_OUT_ALL + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  l2_ar_credit_arbiter_if.slave       bus,
  output logic [TOT_W-1:0]            out_total,
  output logic                        err
);

  localparam int unsigned SRC_W = $clog2(NUM_SI);
  localparam int unsigned CNT_W = $clog2(MAX_OUT_SI + 1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_SI - 1);

  logic [CNT_W-1:0]  cnt_q [NUM_SI];
  logic [CNT_W-1:0]  cnt_d [NUM_SI];
  logic [TOT_W-1:0]  total_q, total_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              err_q, err_d;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;

  logic [NUM_SI-1:0] elig;
  logic [NUM_SI-1:0] inc, dec;
  logic              gnt_vld;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W:0]    scan_idx;
  logic              can_take, accept;
  logic              ret, ret_ok, src_cnt_nz;
  logic [SRC_W-1:0]  ret_src;
  logic [ID_W-1:0]   sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  // Eligibility uses registered counts only, so a returned credit is usable one cycle later.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      elig[i] = bus.s_arvalid[i] & (cnt_q[i] < CNT_W'(MAX_OUT_SI)) &
                (total_q < TOT_W'(MAX_OUT_ALL));
    end
  end

  // Round-robin scan starting at ptr_q; the first eligible index wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SI; k++) begin
      scan_idx = {1'b0, ptr_q} + (SRC_W + 1)'(k);
      if (scan_idx >= (SRC_W + 1)'(NUM_SI)) begin
        scan_idx = scan_idx - (SRC_W + 1)'(NUM_SI);
      end
      if (!gnt_vld && elig[scan_idx[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[SRC_W-1:0];
      end
    end
  end

  assign can_take = ~arvalid_q | bus.m_arready;
  assign accept   = can_take & gnt_vld;

  always_comb begin
    bus.s_arready = '0;
    sel_id        = '0;
    sel_addr      = '0;
    sel_len       = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        bus.s_arready[i] = accept;
        sel_id           = bus.s_arid[i*ID_W +: ID_W];
        sel_addr         = bus.s_araddr[i*ADDR_W +: ADDR_W];
        sel_len          = bus.s_arlen[i*LEN_W +: LEN_W];
      end
    end
  end

  // Credit return. An out-of-range source never matches any i, so it falls into the error path.
  assign ret     = bus.m_rvalid & bus.m_rready & bus.m_rlast;
  assign ret_src = bus.m_rid[SRC_LSB +: SRC_W];

  always_comb begin
    src_cnt_nz = 1'b0;
    for (int i = 0; i < NUM_SI; i++) begin
      if (ret_src == SRC_W'(i) && cnt_q[i] != '0) begin
        src_cnt_nz = 1'b1;
      end
    end
  end

  assign ret_ok = ret & src_cnt_nz & (total_q != '0);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      inc[i]   = accept & (gnt_idx == SRC_W'(i));
      dec[i]   = ret_ok & (ret_src == SRC_W'(i));
      cnt_d[i] = cnt_q[i];
      unique case ({inc[i], dec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    total_d = total_q;
    unique case ({accept, ret_ok})
      2'b10:   total_d = total_q + TOT_W'(1);
      2'b01:   total_d = total_q - TOT_W'(1);
      default: total_d = total_q;
    endcase
  end

  assign ptr_d     = accept ? ((gnt_idx == LAST_IDX) ? '0 : gnt_idx + SRC_W'(1)) : ptr_q;
  assign err_d     = err_q | (ret & ~ret_ok);
  assign arvalid_d = accept | (arvalid_q & ~bus.m_arready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SI; i++) begin
        cnt_q[i] <= '0;
      end
      total_q   <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SI; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      total_q   <= total_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
    end
  end

  // Payload has no reset; it only loads on accept, which keeps it stable while stalled.
  always_ff @(posedge clk) begin
    if (accept) begin
      arid_q   <= sel_id;
      araddr_q <= sel_addr;
      arlen_q  <= sel_len;
    end
  end

  assign bus.m_arid    = arid_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = arlen_q;
  assign bus.m_arvalid = arvalid_q;
  assign out_total     = total_q;
  assign err           = err_q;

endmodule

// File: doc/l2_ar_credit_arbiter.md
Name: l2_ar_credit_arbiter

Overview:
- Arbitrates AXI read-address requests from NUM_SI tile-side requesters onto one L2 master AR port.
- Enforces per-requester and global limits on outstanding reads (credits).
- Credits return when the last R beat of a burst is accepted on the master side; the R channel is snooped only, not routed.
- Sits in front of each L2 master port of the tile-to-L2 crossbar; prevents one tile from monopolising L2 miss bandwidth.

Parameters:
NUM_SI, 4, number of requesters (>=2)
ID_W, 16, AXI ID width
ADDR_W, 64, AXI address width
LEN_W, 8, AXI burst length width
SRC_LSB, 12, lowest bit of the requester index field within ARID/RID; the field is $clog2(NUM_SI) bits wide
MAX_OUT_SI, 4, max outstanding bursts per requester
MAX_OUT_ALL, 16, max outstanding bursts in total

Ports:
clk  in  1  clock
rstn  in  1  synchronous, active-low reset
s_arid  in  NUM_SI*ID_W  requester ARIDs, packed, requester i at [i*ID_W +: ID_W]
s_araddr  in  NUM_SI*ADDR_W  requester addresses, packed
s_arlen  in  NUM_SI*LEN_W  requester burst lengths, packed
s_arvalid  in  NUM_SI  requester valid
s_arready  out  NUM_SI  requester ready
m_arid  out  ID_W  registered master ARID
m_araddr  out  ADDR_W  registered master address
m_arlen  out  LEN_W  registered master length
m_arvalid  out  1  master valid
m_arready  in  1  master ready
m_rid  in  ID_W  snooped R ID
m_rlast  in  1  snooped R last
m_rvalid  in  1  snooped R valid
m_rready  in  1  snooped R ready
out_total  out  $clog2(MAX_OUT_ALL+1)  current global outstanding count
err  out  1  sticky credit-return error

Behaviour:
- Reset: m_arvalid=0, all counters 0, rr pointer 0, err=0, s_arready=0. m_arid, m_araddr and m_arlen are don't-care until the first load.
- Reset takes effect mid-operation regardless of in-flight bursts. All credits are discarded.
- Eligibility: elig[i] = s_arvalid[i] & (cnt[i] < MAX_OUT_SI) & (total < MAX_OUT_ALL).
  - Counts are the registered values.
  - A credit returned in cycle N is usable from cycle N+1.
- Grant: round-robin over elig.
  - Search starts at ptr and wraps NUM_SI-1 -> 0. The first eligible index wins.
  - Combinational within the cycle.
- can_take = !m_arvalid | m_arready.
- s_arready[i] = can_take & elig[i] & (grant==i). At most one bit is set.
- s_arready does not depend on the s_arvalid of other requesters beyond the grant calculation.
- Accept in cycle N (s_arvalid[g] & s_arready[g]):
  - m_ar* load requester g's fields.
  - m_arvalid=1 from cycle N+1. Latency is 1 cycle.
  - Full throughput: back-to-back accepts are allowed while m_arready=1.
- No accept, and m_arvalid & m_arready: m_arvalid <= 0.
- m_ar* are held stable while m_arvalid & !m_arready (AXI compliant).
- ptr <= g+1 (mod NUM_SI) on accept only. ptr is unchanged when idle or stalled.
- Credit take: on accept, cnt[g] and total each increment by 1. Credits are reserved at requester-side accept, not at master handshake.
- Credit return: on m_rvalid & m_rready & m_rlast, with src = m_rid[SRC_LSB +: $clog2(NUM_SI)]:
  - cnt[src] and total each decrement by 1.
  - Non-last beats have no effect.
- Same-cycle take and return:
  - Same counter: net unchanged.
  - Different requesters: each counter is updated independently; total is unchanged.
- Return with src >= NUM_SI, or with cnt[src]==0 or total==0:
  - No counter change; counters saturate at 0.
  - err <= 1, and stays set until reset.
- Counters never exceed their limits, by construction of elig.
- out_total = registered total.

Test Plan:
- Reset then idle: s_arvalid=0 for 10 cycles -> m_arvalid=0, s_arready=0, out_total=0, err=0.
- Single request: s_arvalid[2]=1 with araddr=0x1000, arlen=3, and m_arready=1 -> s_arready[2]=1 in cycle N; m_arvalid=1 with m_araddr=0x1000 and m_arlen=3 in N+1; out_total=1.
- Round-robin: all 4 requesters valid, m_arready=1, RIDs returned promptly -> grant order 0,1,2,3,0,1 on consecutive cycles.
- Per-requester limit: requester 1 is the only valid requester, no R returns -> exactly 4 accepts, then s_arready[1]=0.
  - Return one rlast with RID src field=1 in cycle N -> s_arready[1]=1 again in N+1, not in N.
- Global limit: MAX_OUT_ALL=16, all requesters streaming, no returns -> 16 accepts total, then all s_arready=0 and out_total=16.
- Backpressure and error:
  - m_arready=0 for 5 cycles with m_arvalid=1 -> m_ar* stable, s_arready all 0.
  - Rlast with src=3 while cnt[3]=0 -> err=1, counters unchanged.
  - Then rstn=0 for one cycle -> err=0, out_total=0.
